cordic_multimode: RTL and testbench
===================================

# cordic_multimode

Parametrised iterative CORDIC engine, successor to the fixed 8-bit rotation-only core. Adds:
- configurable data width and iteration count;
- per-transaction rotation/vectoring mode;
- quadrant pre-rotation for full ±π convergence;
- ready/valid handshakes on both sides with output backpressure;
- saturating outputs.

One shared combinational slice is reused once per cycle. The block sits between the sample source and the phase/magnitude consumers in the DSP chain.

## Interface
- `N_FRAC`, default 7: fractional bits. Data width W = N_FRAC+1, Q1.N_FRAC two's complement.
- `ITERATIONS`, default 6: micro-rotations per transaction, legal 1..N_FRAC+1.
- `clk_i` in 1: the single clock; all state changes on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `x_i`, `y_i`, `z_i` in W each: signed operands. z in units of π/2^N_FRAC, so −2^N_FRAC = −π.
- `mode_i` in 1: 0 = rotation (drive z→0), 1 = vectoring (drive y→0). Captured with operands.
- `in_valid_i` in 1: operand valid.
- `in_ready_o` out 1: block can accept.
- `x_o`, `y_o`, `z_o` out W each: results; x/y carry CORDIC gain K (~1.646), uncompensated.
- `sat_o` out 1: x_o or y_o was saturated.
- `out_valid_o` out 1: results valid.
- `out_ready_i` in 1: consumer accepts.

## Operation
- Angle table: elaboration-time constant, angle[i] = floor(2^N_FRAC·atan(2^-i)/π), W bits. Defaults give 32, 18, 9, 5, 2, 1.
- Internal x/y registers are W+2 bits (sign-extended inputs). z register is W bits, wraps modulo 2π.
- States:
  - IDLE: in_ready_o=1.
    - Accept on in_valid_i & in_ready_o: load registers (after pre-rotation), counter=0, latch mode → CALC.
  - CALC: in_ready_o=0. Each cycle, registers ← slice(registers, counter), counter+1.
    - After iteration ITERATIONS−1: latch saturated outputs and sat → DONE.
  - DONE: out_valid_o=1, outputs held stable.
    - On out_valid_o & out_ready_i → IDLE.
  - Illegal state → IDLE.
- Pre-rotation is combinational on inputs at acceptance:
  - Rotation, when z_i[W−1] ≠ z_i[W−2] (|z| > π/2): x=−x_i, y=−y_i, z = z_i with MSB inverted (z−π).
  - Vectoring, when x_i < 0: x=−x_i, y=−y_i, z = z_i with MSB inverted (z+π).
  - Negation is done in W+2 bits, so −2^N_FRAC does not overflow.
- Slice, iteration i, with shifts arithmetic (>>>):
  - d = +1 if (rotation: z ≥ 0) / (vectoring: y < 0), else −1.
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·angle[i].
- Output: x/y clamped to [−2^N_FRAC, 2^N_FRAC−1]. sat_o=1 if either was clamped. z_o = z register.
- in_valid_i is ignored outside IDLE. Operands need not be held after acceptance.

## Timing
- Reset: state=IDLE, counter=0, all data registers 0. Gives x_o=y_o=z_o=0, sat_o=0, out_valid_o=0, in_ready_o=1 on the first cycle after the reset edge.
- Reset asserted in any state, including mid-CALC or DONE: the transaction is abandoned and nothing is emitted.
- Latency: acceptance on edge E; out_valid_o rises after edge E+ITERATIONS.
- Back-to-back with out_ready_i held high: one transaction per ITERATIONS+2 cycles.
  - DONE→IDLE on edge E+ITERATIONS+1.
  - Next acceptance no earlier than edge E+ITERATIONS+2.
- Backpressure: DONE persists indefinitely while out_ready_i=0. x_o, y_o, z_o and sat_o stay constant.
- out_ready_i high outside DONE has no effect.
- in_ready_o and out_valid_o are registered-state decodes. There is no combinational path from in_valid_i or out_ready_i to any output.

## Test plan
- Reset: assert rst_i for 2 cycles mid-CALC → after release out_valid_o=0, in_ready_o=1, outputs 0, and no result emitted for the aborted operand.
- Rotation, defaults: x=64, y=0, z=0, mode=0, out_ready held 1 → out_valid_o after exactly 6 cycles with x_o=106, y_o=−2, z_o=−1, sat_o=0.
- Rotation pre-rotation: x=64, y=0, z=−128, mode=0 → x_o=−106, y_o=2, z_o=−1, sat_o=0.
- Vectoring saturation: x=64, y=64, z=0, mode=1 → x_o=127 (raw 150 clamped), y_o=−1, z_o=33, sat_o=1.
- Backpressure: hold out_ready_i=0 for 5 cycles after out_valid_o rises while pulsing in_valid_i → outputs stable, in_ready_o=0, no new acceptance. Release → IDLE next edge, then the next operand is accepted.
- Throughput: stream 3 transactions with in_valid_i and out_ready_i held high → acceptances exactly 8 cycles apart and results in order.

Source files
------------

// File: rtl/cordic_multimode_if.sv
// cordic_multimode_if: operand/result handshake bundle for cordic_multimode.
//   slave  modport (engine side): takes x_i/y_i/z_i/mode_i/in_valid_i/out_ready_i,
//                                 drives in_ready_o, x_o/y_o/z_o, sat_o, out_valid_o.
//   master modport (source/consumer side): the mirror image.
// Data are Q1.N_FRAC two's complement, W = N_FRAC+1 bits; z is in units of pi/2^N_FRAC.
interface cordic_multimode_if #(
  parameter int unsigned N_FRAC = 7
) ();
  logic signed [N_FRAC:0] x_i;
  logic signed [N_FRAC:0] y_i;
  logic signed [N_FRAC:0] z_i;
  logic                   mode_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic signed [N_FRAC:0] x_o;
  logic signed [N_FRAC:0] y_o;
  logic signed [N_FRAC:0] z_o;
  logic                   sat_o;
  logic                   out_valid_o;
  logic                   out_ready_i;

  modport slave (
    input  x_i, y_i, z_i, mode_i, in_valid_i, out_ready_i,
    output in_ready_o, x_o, y_o, z_o, sat_o, out_valid_o
  );

  modport master (
    output x_i, y_i, z_i, mode_i, in_valid_i, out_ready_i,
    input  in_ready_o, x_o, y_o, z_o, sat_o, out_valid_o
  );
endinterface

// File: rtl/cordic_multimode.sv
// cordic_multimode: iterative CORDIC engine, one micro-rotation per cycle through a
// single shared slice. Rotation mode (mode_i=0) drives z to 0, vectoring (mode_i=1)
// drives y to 0. Inputs are pre-rotated by pi when outside the convergence range.
// Results carry the uncompensated CORDIC gain and are clamped to the Q1.N_FRAC range.
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - cordic_multimode_if.slave: operand ready/valid in, result ready/valid out
module cordic_multimode #(
  parameter int unsigned N_FRAC     = 7,
  parameter int unsigned ITERATIONS = 6
) (
  input logic               clk_i,
  input logic               rst_i,
  cordic_multimode_if.slave bus
);

  localparam int unsigned W    = N_FRAC + 1;
  localparam int unsigned XW   = W + 2;
  localparam int unsigned CntW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ITERATIONS - 1);

  localparam logic signed [W-1:0]  OutHi = {1'b0, {N_FRAC{1'b1}}};
  localparam logic signed [W-1:0]  OutLo = {1'b1, {N_FRAC{1'b0}}};
  localparam logic signed [XW-1:0] SatHi = {2'b00, OutHi};
  localparam logic signed [XW-1:0] SatLo = {2'b11, OutLo};

  // floor(2^N_FRAC * atan(2^-i) / pi), evaluated at elaboration only.
  function automatic logic signed [W-1:0] angle_at(input int unsigned i);
    real a;
    a = $atan(1.0 / (2.0 ** i)) / 3.141592653589793;
    return W'($rtoi($floor(a * (2.0 ** N_FRAC))));
  endfunction

  logic signed [W-1:0] angle_tab [2**CntW];

  for (genvar g = 0; g < 2**CntW; g++) begin : g_angle
    localparam logic signed [W-1:0] Angle = angle_at(g);
    assign angle_tab[g] = Angle;
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q;
  logic [CntW-1:0]      count_q;
  logic                 mode_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [W-1:0]  z_q;
  logic signed [W-1:0]  xo_q, yo_q, zo_q;
  logic                 sat_q;

  // Pre-rotation by pi brings any input angle into the +-pi/2 convergence range.
  logic                 flip;
  logic signed [XW-1:0] x_ext, y_ext, x_pre, y_pre;
  logic signed [W-1:0]  z_pre;

  always_comb begin
    x_ext = {{2{bus.x_i[W-1]}}, bus.x_i};
    y_ext = {{2{bus.y_i[W-1]}}, bus.y_i};
    flip  = bus.mode_i ? bus.x_i[W-1] : (bus.z_i[W-1] ^ bus.z_i[W-2]);
    x_pre = flip ? -x_ext : x_ext;
    y_pre = flip ? -y_ext : y_ext;
    z_pre = flip ? {~bus.z_i[W-1], bus.z_i[W-2:0]} : bus.z_i;
  end

  // Shared micro-rotation slice for iteration count_q.
  logic                 d_pos;
  logic signed [XW-1:0] x_sh, y_sh, x_nx, y_nx;
  logic signed [W-1:0]  z_nx;
  logic signed [W-1:0]  x_cl, y_cl;
  logic                 x_clip, y_clip;

  always_comb begin
    x_sh  = x_q >>> count_q;
    y_sh  = y_q >>> count_q;
    d_pos = mode_q ? y_q[XW-1] : ~z_q[W-1];
    if (d_pos) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - angle_tab[count_q];
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + angle_tab[count_q];
    end

    x_clip = 1'b1;
    if (x_nx > SatHi) begin
      x_cl = OutHi;
    end else if (x_nx < SatLo) begin
      x_cl = OutLo;
    end else begin
      x_cl   = x_nx[W-1:0];
      x_clip = 1'b0;
    end

    y_clip = 1'b1;
    if (y_nx > SatHi) begin
      y_cl = OutHi;
    end else if (y_nx < SatLo) begin
      y_cl = OutLo;
    end else begin
      y_cl   = y_nx[W-1:0];
      y_clip = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      count_q <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid_i) begin
            x_q     <= x_pre;
            y_q     <= y_pre;
            z_q     <= z_pre;
            mode_q  <= bus.mode_i;
            count_q <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          x_q     <= x_nx;
          y_q     <= y_nx;
          z_q     <= z_nx;
          count_q <= count_q + CntW'(1);
          if (count_q == LastCnt) begin
            xo_q    <= x_cl;
            yo_q    <= y_cl;
            zo_q    <= z_nx;
            sat_q   <= x_clip | y_clip;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs decode registered state only; no input-to-output paths.
  assign bus.in_ready_o  = (state_q == StIdle);
  assign bus.out_valid_o = (state_q == StDone);
  assign bus.x_o         = xo_q;
  assign bus.y_o         = yo_q;
  assign bus.z_o         = zo_q;
  assign bus.sat_o       = sat_q;

endmodule

// File: tb/tb_cordic_multimode.sv
// Bench for cordic_multimode: directed reset/backpressure/throughput steps plus random
// operands checked against an integer CORDIC model built from the angle formula.
module tb_cordic_multimode;
  localparam int N  = 7;
  localparam int IT = 6;
  localparam int W  = N + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_multimode_if #(.N_FRAC(N)) bus ();

  cordic_multimode #(.N_FRAC(N), .ITERATIONS(IT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ang [IT];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor division by 2^s, i.e. an arithmetic right shift.
  function automatic int asr(input int v, input int s);
    int p;
    p = 1 << s;
    return (v >= 0) ? v / p : -((-v + p - 1) / p);
  endfunction

  // Reduce an angle to the W-bit signed range (modulo 2*pi).
  function automatic int wrapz(input int v);
    int m;
    m = ((v % (1 << W)) + (1 << W)) % (1 << W);
    return (m >= (1 << N)) ? m - (1 << W) : m;
  endfunction

  task automatic model(input int x, input int y, input int z, input int m,
                       output int xo, output int yo, output int zo, output int so);
    int cx, cy, cz, nx, ny, lim, half;
    bit turn, dpos;
    half = 1 << (N - 1);
    lim  = 1 << N;
    turn = (m == 0) ? (z >= half || z < -half) : (x < 0);
    if (turn) begin
      cx = -x; cy = -y; cz = wrapz(z + lim);
    end else begin
      cx = x;  cy = y;  cz = z;
    end
    for (int i = 0; i < IT; i++) begin
      dpos = (m == 0) ? (cz >= 0) : (cy < 0);
      if (dpos) begin
        nx = cx - asr(cy, i); ny = cy + asr(cx, i); cz = wrapz(cz - ang[i]);
      end else begin
        nx = cx + asr(cy, i); ny = cy - asr(cx, i); cz = wrapz(cz + ang[i]);
      end
      cx = nx; cy = ny;
    end
    so = 0;
    if (cx > lim - 1) begin cx = lim - 1; so = 1; end
    if (cx < -lim)    begin cx = -lim;    so = 1; end
    if (cy > lim - 1) begin cy = lim - 1; so = 1; end
    if (cy < -lim)    begin cy = -lim;    so = 1; end
    xo = cx; yo = cy; zo = cz;
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic drive_ops(input int x, input int y, input int z, input int m);
    bus.x_i    = 8'(x);
    bus.y_i    = 8'(y);
    bus.z_i    = 8'(z);
    bus.mode_i = m[0];
  endtask

  // Presents one operand while idle, drops it after acceptance, waits for the result.
  task automatic send_wait(input int x, input int y, input int z, input int m,
                           output int lat);
    drive_ops(x, y, z, m);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    drive_ops(rnd_op(), rnd_op(), rnd_op(), int'($urandom_range(1)));
    lat = 0;
    while (!bus.out_valid_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_model(input string tag, input int x, input int y, input int z,
                             input int m);
    int ex, ey, ez, es;
    model(x, y, z, m, ex, ey, ez, es);
    check({tag, ".x"}, bus.x_o, ex);
    check({tag, ".y"}, bus.y_o, ey);
    check({tag, ".z"}, bus.z_o, ez);
    check({tag, ".sat"}, bus.sat_o, es);
  endtask

  initial begin
    int lat, seen, cyc, n_acc, n_res, rx, ry, rz, rm;
    bit acc_now;
    int tx [3], ty [3], tz [3], tm [3], acc_cyc [3];

    for (int i = 0; i < IT; i++) begin
      ang[i] = $rtoi($floor(real'(1 << N) * $atan(1.0 / (2.0 ** i)) / $acos(-1.0)));
    end

    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    drive_ops(0, 0, 0, 0);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst.out_valid", bus.out_valid_o, 0);
    check("rst.in_ready", bus.in_ready_o, 1);
    check("rst.x", bus.x_o, 0);
    check("rst.y", bus.y_o, 0);
    check("rst.z", bus.z_o, 0);
    check("rst.sat", bus.sat_o, 0);
    rst = 1'b0;

    // Rotation, no pre-rotation
    send_wait(64, 0, 0, 0, lat);
    check("rot.lat", lat, IT);
    check("rot.x", bus.x_o, 106);
    check("rot.y", bus.y_o, -2);
    check("rot.z", bus.z_o, -1);
    check("rot.sat", bus.sat_o, 0);
    @(posedge clk); #1;
    check("rot.back_idle", bus.in_ready_o, 1);

    // Rotation with pi pre-rotation
    send_wait(64, 0, -128, 0, lat);
    check("rotpi.x", bus.x_o, -106);
    check("rotpi.y", bus.y_o, 2);
    check("rotpi.z", bus.z_o, -1);
    check("rotpi.sat", bus.sat_o, 0);
    @(posedge clk); #1;

    // Vectoring with saturation
    send_wait(64, 64, 0, 1, lat);
    check("vec.x", bus.x_o, 127);
    check("vec.y", bus.y_o, -1);
    check("vec.z", bus.z_o, 33);
    check("vec.sat", bus.sat_o, 1);
    @(posedge clk); #1;

    // Reset mid-CALC abandons the transaction
    drive_ops(50, 20, 10, 0);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.out_valid", bus.out_valid_o, 0);
    check("abort.in_ready", bus.in_ready_o, 1);
    check("abort.x", bus.x_o, 0);
    check("abort.y", bus.y_o, 0);
    check("abort.z", bus.z_o, 0);
    check("abort.sat", bus.sat_o, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) seen++;
    end
    check("abort.no_emit", seen, 0);

    // Backpressure: DONE held, extra operands ignored
    bus.out_ready_i = 1'b0;
    rx = rnd_op(); ry = rnd_op(); rz = rnd_op(); rm = 1;
    send_wait(rx, ry, rz, rm, lat);
    check("bp.lat", lat, IT);
    for (int i = 0; i < 5; i++) begin
      drive_ops(rnd_op(), rnd_op(), rnd_op(), 0);
      bus.in_valid_i = 1'b1;
      @(posedge clk); #1;
      check("bp.out_valid", bus.out_valid_o, 1);
      check("bp.in_ready", bus.in_ready_o, 0);
      check_model("bp.hold", rx, ry, rz, rm);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp.release_valid", bus.out_valid_o, 0);
    check("bp.release_ready", bus.in_ready_o, 1);
    rx = rnd_op(); ry = rnd_op(); rz = rnd_op(); rm = 0;
    send_wait(rx, ry, rz, rm, lat);
    check("bp.next_lat", lat, IT);
    check_model("bp.next", rx, ry, rz, rm);
    @(posedge clk); #1;

    // Throughput: three back-to-back transactions
    for (int i = 0; i < 3; i++) begin
      tx[i] = rnd_op(); ty[i] = rnd_op(); tz[i] = rnd_op();
      tm[i] = int'($urandom_range(1)); acc_cyc[i] = 0;
    end
    drive_ops(tx[0], ty[0], tz[0], tm[0]);
    bus.in_valid_i = 1'b1;
    cyc = 0; n_acc = 0; n_res = 0;
    while (n_res < 3 && cyc < 100) begin
      acc_now = bus.in_ready_o && bus.in_valid_i;
      @(posedge clk); #1;
      cyc++;
      if (acc_now && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) drive_ops(tx[n_acc], ty[n_acc], tz[n_acc], tm[n_acc]);
        else bus.in_valid_i = 1'b0;
      end
      if (bus.out_valid_o && n_res < 3) begin
        check_model("tput.res", tx[n_res], ty[n_res], tz[n_res], tm[n_res]);
        n_res++;
      end
    end
    bus.in_valid_i = 1'b0;
    check("tput.results", n_res, 3);
    check("tput.gap1", acc_cyc[1] - acc_cyc[0], IT + 2);
    check("tput.gap2", acc_cyc[2] - acc_cyc[1], IT + 2);
    @(posedge clk); #1;

    // Random operands in both modes
    for (int k = 0; k < 30; k++) begin
      rx = rnd_op(); ry = rnd_op(); rz = rnd_op(); rm = int'($urandom_range(1));
      send_wait(rx, ry, rz, rm, lat);
      check("rnd.lat", lat, IT);
      check_model("rnd", rx, ry, rz, rm);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
